// File: rtl/util_pktbuf_pkg.sv
// Shared types and helpers for the util_pktbuf store-and-forward buffer.
//   - write/read FSM state enums
//   - desc_t descriptor {level, length}; fields sized for the widest supported
//     configuration, the top level uses only the low LVL_W / ADDR_WIDTH+1 bits
//   - bit_width(): clog2 with a floor of 1, for signals that must exist even
//     when there is only one choice
//   - DROP_CNT_W: width of the drop statistics counter
package util_pktbuf_pkg;

  localparam int unsigned DROP_CNT_W = 16;
  localparam int unsigned DESC_LVL_W = 8;
  localparam int unsigned DESC_LEN_W = 16;

  typedef enum logic [1:0] {
    W_IDLE,
    W_PKT,
    W_DROP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_XFER
  } rd_state_e;

  typedef struct packed {
    logic [DESC_LVL_W-1:0] level;
    logic [DESC_LEN_W-1:0] length;
  } desc_t;

  function automatic int unsigned bit_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/util_pktbuf_ram.sv
// Simple dual-port RAM for the packet buffer: one write port, one read port
// with a registered read (data appears the cycle after re is sampled).
// Ports:
//   clk    - clock
//   we     - write enable, waddr/wdata - write address/data
//   re     - read enable,  raddr       - read address
//   rdata  - read data register (not reset; qualified by the caller)
module util_pktbuf_ram
  import util_pktbuf_pkg::*;
#(
  parameter int unsigned WIDTH      = 68,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/util_pktbuf_arbreq.sv
// Single-channel store-and-forward packet buffer with arbitration request.
// Packets are written into a data RAM; once the eop beat is stored a
// descriptor {level, length} is pushed and a one-hot request is raised for
// the head packet. On grant the packet is read out back-to-back.
// Incomplete, oversized or overflowing packets are discarded by rewinding
// the write pointer to the last committed position.
// Ports:
//   clk_arbit, rst_n (async, active-low)
//   din_*            - input packet stream (level on sop, empty on eop)
//   arbit_request    - one-hot request, bit = head packet level
//   arbit_grant      - grant, sampled only while requesting
//   arbit_eop        - high in the cycle the last word is issued
//   dout_*           - output packet stream, OUT_DELAY cycles after issue
//   pkt_count        - committed packets waiting
//   drop_count       - saturating drop counter; only built when
//                      UTIL_PKTBUF_DROP_STATS_EN is defined, else tied to 0
module util_pktbuf_arbreq
  import util_pktbuf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned EMPT_WIDTH  = 3,
  parameter int unsigned ARBIT_LEVEL = 2,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DESC_AW     = 4,
  parameter int unsigned OUT_DELAY   = 1,
  localparam int unsigned LVL_W      = bit_width(ARBIT_LEVEL)
) (
  input  logic                  clk_arbit,
  input  logic                  rst_n,
  input  logic                  din_sop,
  input  logic                  din_eop,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic [EMPT_WIDTH-1:0] din_empty,
  input  logic [LVL_W-1:0]      din_level,
  output logic [ARBIT_LEVEL-1:0] arbit_request,
  input  logic                  arbit_grant,
  output logic                  arbit_eop,
  output logic                  dout_sop,
  output logic                  dout_eop,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic [EMPT_WIDTH-1:0] dout_empty,
  output logic [DESC_AW:0]      pkt_count,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int unsigned RAM_W = DATA_WIDTH + EMPT_WIDTH + 1;
  localparam int unsigned PW    = RAM_W + 2;
  localparam logic [LVL_W-1:0]      MAX_LVL   = LVL_W'(ARBIT_LEVEL - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   L_ONE     = (ADDR_WIDTH + 1)'(1);
  localparam logic [DESC_AW-1:0]    D_ONE     = DESC_AW'(1);
  localparam logic [DESC_AW:0]      C_ONE     = (DESC_AW + 1)'(1);
  localparam logic [DESC_AW:0]      DESC_FULL = {1'b1, {DESC_AW{1'b0}}};

  // ---------------------------------------------------------------- write side
  wr_state_e             wr_state_q, wr_state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_cmt_q, wr_cmt_d;
  logic [ADDR_WIDTH:0]   wr_len_q, wr_len_d;
  logic [LVL_W-1:0]      wr_level_q, wr_level_d;
  logic [LVL_W-1:0]      lvl_clamped;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic                  push;
  desc_t                 push_desc;
  logic [1:0]            drop_inc;
  logic                  start_pkt;
  logic                  full_at_ptr, full_at_cmt, desc_full;

  // read side signals used by the full check
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DESC_AW:0]      desc_cnt_q;

  assign lvl_clamped = (din_level > MAX_LVL) ? MAX_LVL : din_level;
  // One word is kept free so that full and empty are distinguishable.
  assign full_at_ptr = ((wr_ptr_q + A_ONE) == rd_ptr_q);
  assign full_at_cmt = ((wr_cmt_q + A_ONE) == rd_ptr_q);
  assign desc_full   = (desc_cnt_q == DESC_FULL);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_cmt_d   = wr_cmt_q;
    wr_len_d   = wr_len_q;
    wr_level_d = wr_level_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_ptr_q;
    push       = 1'b0;
    push_desc  = '0;
    drop_inc   = 2'd0;
    start_pkt  = 1'b0;

    if (din_valid) begin
      unique case (wr_state_q)
        W_IDLE: start_pkt = din_sop;
        W_DROP: begin
          if (din_sop) begin
            start_pkt = 1'b1;
          end else if (din_eop) begin
            wr_state_d = W_IDLE;
          end
        end
        W_PKT: begin
          if (din_sop) begin
            // Missing eop: discard the partial packet, restart at wr_cmt.
            drop_inc  = 2'd1;
            start_pkt = 1'b1;
          end else if (full_at_ptr || (din_eop && desc_full)) begin
            wr_ptr_d   = wr_cmt_q;
            drop_inc   = 2'd1;
            wr_state_d = din_eop ? W_IDLE : W_DROP;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + A_ONE;
            wr_len_d = wr_len_q + L_ONE;
            if (din_eop) begin
              push             = 1'b1;
              push_desc.level  = DESC_LVL_W'(wr_level_q);
              push_desc.length = DESC_LEN_W'(wr_len_q + L_ONE);
              wr_cmt_d         = wr_ptr_q + A_ONE;
              wr_state_d       = W_IDLE;
            end
          end
        end
        default: wr_state_d = W_IDLE;
      endcase
    end

    if (start_pkt) begin
      ram_waddr  = wr_cmt_q;
      wr_level_d = lvl_clamped;
      wr_len_d   = L_ONE;
      if (full_at_cmt || (din_eop && desc_full)) begin
        wr_ptr_d   = wr_cmt_q;
        drop_inc   = drop_inc + 2'd1;
        wr_state_d = din_eop ? W_IDLE : W_DROP;
      end else begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_cmt_q + A_ONE;
        if (din_eop) begin
          push             = 1'b1;
          push_desc.level  = DESC_LVL_W'(lvl_clamped);
          push_desc.length = DESC_LEN_W'(L_ONE);
          wr_cmt_d         = wr_cmt_q + A_ONE;
          wr_state_d       = W_IDLE;
        end else begin
          wr_state_d = W_PKT;
        end
      end
    end
  end

  always_ff @(posedge clk_arbit or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      wr_ptr_q   <= '0;
      wr_cmt_q   <= '0;
      wr_len_q   <= '0;
      wr_level_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_cmt_q   <= wr_cmt_d;
      wr_len_q   <= wr_len_d;
      wr_level_q <= wr_level_d;
    end
  end

  // ----------------------------------------------------------- descriptor FIFO
  desc_t              desc_mem [2**DESC_AW];
  logic [DESC_AW-1:0] desc_wp_q, desc_rp_q;
  desc_t              head;
  logic               pop;
  logic               unused_head;

  assign head        = desc_mem[desc_rp_q];
  assign unused_head = ^head;

  always_ff @(posedge clk_arbit) begin
    if (push) begin
      desc_mem[desc_wp_q] <= push_desc;
    end
  end

  always_ff @(posedge clk_arbit or negedge rst_n) begin
    if (!rst_n) begin
      desc_wp_q  <= '0;
      desc_rp_q  <= '0;
      desc_cnt_q <= '0;
    end else begin
      if (push) desc_wp_q <= desc_wp_q + D_ONE;
      if (pop)  desc_rp_q <= desc_rp_q + D_ONE;
      case ({push, pop})
        2'b10:   desc_cnt_q <= desc_cnt_q + C_ONE;
        2'b01:   desc_cnt_q <= desc_cnt_q - C_ONE;
        default: desc_cnt_q <= desc_cnt_q;
      endcase
    end
  end

  assign pkt_count = desc_cnt_q;

  // ----------------------------------------------------------------- read side
  rd_state_e              rd_state_q, rd_state_d;
  logic [ADDR_WIDTH:0]    rem_q, rem_d;
  logic                   first_q, first_d;
  logic [ARBIT_LEVEL-1:0] req_q, req_d;
  logic                   ram_re;
  logic                   issue_sop;
  logic                   issue_v_q, issue_sop_q;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    rem_d      = rem_q;
    first_d    = first_q;
    req_d      = req_q;
    ram_re     = 1'b0;
    pop        = 1'b0;
    arbit_eop  = 1'b0;
    issue_sop  = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (desc_cnt_q != '0) begin
          rd_state_d = R_REQ;
          req_d      = ARBIT_LEVEL'(1) << head.level[LVL_W-1:0];
          rem_d      = head.length[ADDR_WIDTH:0];
        end
      end
      R_REQ: begin
        if (arbit_grant) begin
          rd_state_d = R_XFER;
          req_d      = '0;
          first_d    = 1'b1;
        end
      end
      R_XFER: begin
        // Grant is not looked at here: a started packet always completes.
        ram_re    = 1'b1;
        rd_ptr_d  = rd_ptr_q + A_ONE;
        rem_d     = rem_q - L_ONE;
        issue_sop = first_q;
        first_d   = 1'b0;
        if (rem_q == L_ONE) begin
          arbit_eop  = 1'b1;
          pop        = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_arbit or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q  <= R_IDLE;
      rd_ptr_q    <= '0;
      rem_q       <= '0;
      first_q     <= 1'b0;
      req_q       <= '0;
      issue_v_q   <= 1'b0;
      issue_sop_q <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      rd_ptr_q    <= rd_ptr_d;
      rem_q       <= rem_d;
      first_q     <= first_d;
      req_q       <= req_d;
      issue_v_q   <= ram_re;
      issue_sop_q <= issue_sop;
    end
  end

  assign arbit_request = req_q;

  // ---------------------------------------------------------------------- RAM
  logic [RAM_W-1:0] ram_rdata;

  util_pktbuf_ram #(
    .WIDTH      (RAM_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk_arbit),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata ({din_eop, din_empty, din_data}),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // ------------------------------------------------------------ output stage
  // RAM read data is not reset, so it is masked by the issue valid here.
  logic [PW-1:0] stage0, out_word;

  assign stage0 = issue_v_q ? {1'b1, issue_sop_q, ram_rdata} : '0;

  if (OUT_DELAY <= 1) begin : g_no_dly
    assign out_word = stage0;
  end else begin : g_dly
    logic [PW-1:0] dly_q [OUT_DELAY-1];
    always_ff @(posedge clk_arbit or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(OUT_DELAY) - 1; i++) dly_q[i] <= '0;
      end else begin
        dly_q[0] <= stage0;
        for (int i = 1; i < int'(OUT_DELAY) - 1; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign out_word = dly_q[OUT_DELAY-2];
  end

  assign dout_valid = out_word[PW-1];
  assign dout_sop   = out_word[PW-2];
  assign dout_eop   = out_word[RAM_W-1];
  assign dout_empty = dout_eop ? out_word[DATA_WIDTH +: EMPT_WIDTH] : '0;
  assign dout_data  = out_word[DATA_WIDTH-1:0];

  // ------------------------------------------------------------- drop stats
`ifdef UTIL_PKTBUF_DROP_STATS_EN
  logic [DROP_CNT_W:0]   drop_sum;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  assign drop_sum = {1'b0, drop_cnt_q} + (DROP_CNT_W + 1)'(drop_inc);

  always_ff @(posedge clk_arbit or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end
  end

  assign drop_count = drop_cnt_q;
`else
  logic unused_drop_inc;
  assign unused_drop_inc = ^drop_inc;
  assign drop_count      = '0;
`endif

endmodule
